// File: rtl/dut_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready pipeline with per-word transform on accept,
// synchronous flush and a wrapping delivered-word counter.
module dut_pipe #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   vin,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   vout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] count
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            en;
    logic [COUNT_W-1:0]          count_q, count_d;
    logic [WIDTH-1:0]            xf;

    // Ready chain walks from the sink back to stage 0; a stage may move if it
    // is empty or everything downstream of it moves this cycle.
    always_comb begin : ready_chain
        logic down;
        down = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            down  = !v_q[i] || down;
            en[i] = down;
        end
    end

    always_comb begin
        xf = vin;
        case (mode)
            2'b00: xf = vin;
            2'b01: xf = ~vin;
            2'b10: xf = '0;
            default: begin
                for (int i = 0; i < WIDTH; i++) xf[i] = vin[WIDTH-1-i];
            end
        endcase
    end

    assign in_ready  = en[0] && !flush && !reset;
    assign vout      = data_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign count     = count_q;

    always_comb begin
        data_d  = data_q;
        v_d     = v_q;
        count_d = count_q;
        if (en[0]) begin
            data_d[0] = xf;
            v_d[0]    = in_valid && in_ready;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (en[i]) begin
                data_d[i] = data_q[i-1];
                v_d[i]    = v_q[i-1];
            end
        end
        // A flush swallows any output handshake in the same cycle.
        if (flush) begin
            v_d = '0;
        end else if (out_valid && out_ready) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            v_q     <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dut_pipe.sv
// Bench for dut_pipe: directed scenarios plus a randomized run scored against a
// FIFO-level reference model of the pipe.
module tb_dut_pipe;
    localparam int W  = 8;
    localparam int D  = 2;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  vin = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  vout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    dut_pipe #(.WIDTH(W), .DEPTH(D), .COUNT_W(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .mode(mode), .vin(vin),
        .in_valid(in_valid), .in_ready(in_ready), .vout(vout),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    function automatic logic [W-1:0] ref_xf(input logic [W-1:0] d, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'd0: r = d;
            2'd1: r = ~d;
            2'd2: r = '0;
            default: r = {<<{d}};
        endcase
        return r;
    endfunction

    task automatic drive_idle();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; mode = 2'b00; vin = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        drive_idle();
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vecs++; if (vout !== '0) begin errs++; $display("FAIL rst_vout: got %h want 00", vout); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        vecs++; if (count !== '0) begin errs++; $display("FAIL rst_count: got %0d want 0", count); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        #2;
        reset = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 3); vin = W'(t + 1); out_ready = 1'b1; mode = 2'b00;
            @(negedge clock);
            vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready t=%0d: got %b want 1", t, in_ready); end
            vecs++; if (out_valid !== (t >= 2 && t <= 4)) begin errs++; $display("FAIL stream_out_valid t=%0d: got %b want %b", t, out_valid, (t >= 2 && t <= 4)); end
            if (t >= 2 && t <= 4) begin
                vecs++; if (vout !== W'(t - 1)) begin errs++; $display("FAIL stream_vout t=%0d: got %h want %h", t, vout, W'(t - 1)); end
            end
            if (t == 5) begin
                vecs++; if (count !== CW'(3)) begin errs++; $display("FAIL stream_count: got %0d want 3", count); end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_modes();
        logic [W-1:0] exp_v [5];
        exp_v = '{8'h00, 8'h00, 8'hCA, 8'h00, 8'hAC};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            out_ready = 1'b1;
            in_valid  = (t < 3);
            vin       = (t < 3) ? 8'h35 : 8'hFF;
            mode      = (t < 3) ? 2'(t + 1) : 2'b00;
            @(negedge clock);
            vecs++; if (out_valid !== (t >= 2)) begin errs++; $display("FAIL modes_out_valid t=%0d: got %b want %b", t, out_valid, (t >= 2)); end
            if (t >= 2) begin
                vecs++; if (vout !== exp_v[t]) begin errs++; $display("FAIL modes_vout t=%0d: got %h want %h", t, vout, exp_v[t]); end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_backpressure();
        logic          exp_rdy, exp_ov;
        logic [W-1:0]  exp_vo;
        do_reset();
        for (int t = 0; t < 9; t++) begin
            in_valid  = (t <= 5);
            vin       = (t == 0) ? 8'h01 : (t == 1) ? 8'h02 : 8'h03;
            out_ready = (t >= 5);
            exp_rdy   = !(t >= 2 && t <= 4);
            exp_ov    = (t >= 2 && t <= 7);
            exp_vo    = (t <= 5) ? 8'h01 : (t == 6) ? 8'h02 : 8'h03;
            @(negedge clock);
            vecs++; if (in_ready !== exp_rdy) begin errs++; $display("FAIL bp_in_ready t=%0d: got %b want %b", t, in_ready, exp_rdy); end
            vecs++; if (out_valid !== exp_ov) begin errs++; $display("FAIL bp_out_valid t=%0d: got %b want %b", t, out_valid, exp_ov); end
            if (exp_ov) begin
                vecs++; if (vout !== exp_vo) begin errs++; $display("FAIL bp_vout t=%0d: got %h want %h", t, vout, exp_vo); end
            end
            if (t == 8) begin
                vecs++; if (count !== CW'(3)) begin errs++; $display("FAIL bp_count: got %0d want 3", count); end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; vin = 8'hAA; out_ready = 1'b0;
        @(posedge clock); #1;
        vin = 8'hBB;
        @(posedge clock); #1;
        flush = 1'b1; vin = 8'hCC; out_ready = 1'b1;
        @(negedge clock);
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        vecs++; if (out_valid !== 1'b1 || vout !== 8'hAA) begin errs++; $display("FAIL flush_pre_vout: got %b/%h want 1/aa", out_valid, vout); end
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_out_valid t=%0d: got %b want 0", t, out_valid); end
            vecs++; if (count !== '0) begin errs++; $display("FAIL flush_count t=%0d: got %0d want 0", t, count); end
            vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready_after t=%0d: got %b want 1", t, in_ready); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            in_valid = (t < 17); vin = W'(t); out_ready = 1'b1;
            n = (t < 2) ? 0 : (t - 2 > 17) ? 17 : t - 2;
            @(negedge clock);
            vecs++; if (count !== CW'(n % 16)) begin errs++; $display("FAIL wrap_count t=%0d: got %0d want %0d", t, count, n % 16); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_random();
        logic [W-1:0]  q [$];
        logic [CW-1:0] cnt_m;
        logic          exp_rdy, held;
        logic [W-1:0]  held_v;
        int            stall;
        do_reset();
        cnt_m = '0; held = 1'b0; held_v = '0; stall = 0;
        for (int t = 0; t < 400; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom_range(0, 3));
            vin       = W'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clock);
            exp_rdy = !flush && (q.size() < D || out_ready);
            vecs++; if (in_ready !== exp_rdy) begin errs++; $display("FAIL rnd_in_ready t=%0d: got %b want %b", t, in_ready, exp_rdy); end
            vecs++; if (count !== cnt_m) begin errs++; $display("FAIL rnd_count t=%0d: got %0d want %0d", t, count, cnt_m); end
            if (q.size() == 0) begin
                vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rnd_spurious t=%0d: got out_valid %b want 0", t, out_valid); end
            end else begin
                if (q.size() == D) begin
                    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rnd_full_valid t=%0d: got %b want 1", t, out_valid); end
                end
                if (out_valid === 1'b1) begin
                    vecs++; if (vout !== q[0]) begin errs++; $display("FAIL rnd_vout t=%0d: got %h want %h", t, vout, q[0]); end
                end
            end
            if (held) begin
                vecs++; if (out_valid !== 1'b1 || vout !== held_v) begin errs++; $display("FAIL rnd_stable t=%0d: got %b/%h want 1/%h", t, out_valid, vout, held_v); end
            end
            stall = (!flush && q.size() > 0 && out_valid !== 1'b1) ? stall + 1 : 0;
            if (stall > 0) begin
                vecs++; if (stall > D - 1) begin errs++; $display("FAIL rnd_latency t=%0d: got %0d idle cycles want <= %0d", t, stall, D - 1); end
            end
            held   = out_valid && !out_ready && !flush;
            held_v = vout;
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    cnt_m = cnt_m + 1'b1;
                end
                if (in_valid && exp_rdy) q.push_back(ref_xf(vin, mode));
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; vin = W'(8'h40 + t); out_ready = 1'b1;
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        @(negedge clock);
        vecs++; if (out_valid !== 1'b1 || count !== CW'(3)) begin errs++; $display("FAIL mid_pre: got %b/%0d want 1/3", out_valid, count); end
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        vecs++; if (vout !== '0) begin errs++; $display("FAIL mid_vout: got %h want 00", vout); end
        vecs++; if (count !== '0) begin errs++; $display("FAIL mid_count: got %0d want 0", count); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL mid_release_in_ready: got %b want 1", in_ready); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_release_out_valid: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_modes();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
